spike_collector: RTL and testbench

Synchronous sink for the request/acknowledge outputs of the last neuron layer. It closes the 4-phase handshake on every `req_out` line of a `layer` instance, counts completed spikes per output neuron over a programmable observation window, and reports the winning (most-spiking) neuron at window end. It sits between the asynchronous network and the clocked readout/host logic.

---
 rtl/spike_collector_if.sv | 15 +
 rtl/spike_collector.sv | 102 ++++++++++
 tb/tb_spike_collector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spike_collector_if.sv
// spike_collector_if: request/ack lines, window control and result bus between the spike collector and its host.
interface spike_collector_if #(
   parameter int NEURONS = 2,
   parameter int CNT_W   = 8
);
   logic [NEURONS-1:0]         req;
   logic [NEURONS-1:0]         ack;
   logic                       start;
   logic                       busy;
   logic                       result_valid;
   logic [$clog2(NEURONS)-1:0] winner;
   logic [NEURONS*CNT_W-1:0]   counts;
   modport master (output req, start, input ack, busy, result_valid, winner, counts);
   modport slave  (input req, start, output ack, busy, result_valid, winner, counts);
endinterface

// File: rtl/spike_collector.sv
// spike_collector: closes 4-phase handshakes, counts spikes per neuron over a window and reports the winner.
// SPIKE_COLLECTOR_SYNC_EN adds a 2-flop synchronizer on every req line.
module spike_collector #(
   parameter int NEURONS   = 2,
   parameter int CNT_W     = 8,
   parameter int WINDOW    = 100,
   parameter int ACK_DELAY = 2
) (
   input logic              clk,
   input logic              rst,
   spike_collector_if.slave sc_io
);
   localparam int WW = $clog2(NEURONS);
   localparam int TW = $clog2(WINDOW + 1);
   localparam int DW = ACK_DELAY > 0 ? $clog2(ACK_DELAY + 1) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, ACK} hs_t;
   hs_t              st_q  [NEURONS];
   logic [DW-1:0]    dly_q [NEURONS];
   logic [CNT_W-1:0] cnt_q [NEURONS];
   logic [CNT_W-1:0] cnt_d [NEURONS];
   logic [CNT_W-1:0] best;
   logic [NEURONS-1:0] sreq, spk, ack_q;
   logic [TW-1:0] tmr_q, tmr_d;
   logic busy_q, busy_d, rv_q, rv_d;
   logic [WW-1:0] win_q, win_d;
`ifdef SPIKE_COLLECTOR_SYNC_EN
   logic [NEURONS-1:0] s1_q, s2_q;
   always_ff @(posedge clk)
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= sc_io.req;
         s2_q <= s1_q;
      end
   assign sreq = s2_q;
`else
   assign sreq = sc_io.req;
`endif
   // Timer is preloaded with ACK_DELAY-1 so ack rises ACK_DELAY cycles after the first sreq cycle.
   always_ff @(posedge clk)
      for (int i = 0; i < NEURONS; i++)
         if (rst) begin
            st_q[i]  <= IDLE;
            dly_q[i] <= '0;
            ack_q[i] <= 1'b0;
         end else
            case (st_q[i])
               IDLE: if (sreq[i]) begin
                  st_q[i]  <= ACK_DELAY == 0 ? ACK : WAIT;
                  ack_q[i] <= ACK_DELAY == 0;
                  dly_q[i] <= DW'(ACK_DELAY > 0 ? ACK_DELAY - 1 : 0);
               end
               WAIT: if (dly_q[i] == '0) begin
                  st_q[i]  <= ACK;
                  ack_q[i] <= 1'b1;
               end else
                  dly_q[i] <= dly_q[i] - DW'(1);
               ACK: if (!sreq[i]) begin
                  st_q[i]  <= IDLE;
                  ack_q[i] <= 1'b0;
               end
               default: st_q[i] <= IDLE;
            endcase
   always_comb begin
      win_d = '0;
      best  = '0;
      spk   = '0;
      for (int i = 0; i < NEURONS; i++) begin
         spk[i]   = (st_q[i] == WAIT && dly_q[i] == '0) || (ACK_DELAY == 0 && st_q[i] == IDLE && sreq[i]);
         cnt_d[i] = sc_io.start ? '0 : (spk[i] && busy_q && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
         if (i == 0 || cnt_d[i] > best) begin
            best  = cnt_d[i];
            win_d = WW'(i);
         end
      end
   end
   assign busy_d = sc_io.start || (busy_q && tmr_q != '0);
   assign tmr_d  = sc_io.start ? TW'(WINDOW - 1) : (busy_q && tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
   assign rv_d   = busy_q && tmr_q == '0 && !sc_io.start;
   always_ff @(posedge clk)
      if (rst) begin
         busy_q <= 1'b0;
         tmr_q  <= '0;
         rv_q   <= 1'b0;
         win_q  <= '0;
         for (int i = 0; i < NEURONS; i++) cnt_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         tmr_q  <= tmr_d;
         rv_q   <= rv_d;
         win_q  <= rv_d ? win_d : win_q;
         for (int i = 0; i < NEURONS; i++) cnt_q[i] <= cnt_d[i];
      end
   assign sc_io.ack          = ack_q;
   assign sc_io.busy         = busy_q;
   assign sc_io.result_valid = rv_q;
   assign sc_io.winner       = win_q;
   for (genvar g = 0; g < NEURONS; g++) begin : g_cnt
      assign sc_io.counts[g*CNT_W +: CNT_W] = cnt_q[g];
   end
endmodule

// File: tb/tb_spike_collector.sv
// tb_spike_collector: directed checks of handshake timing, window counting, ties, restart, saturation and reset.
`timescale 1ns/1ps
module tb_spike_collector;
`ifdef SPIKE_COLLECTOR_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int AD   = 2;
   localparam int RISE = LAT + AD + 1;
   localparam int FALL = LAT + 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, s0 = 0, old = 0, total = 0, bad = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   spike_collector_if #(.NEURONS(2), .CNT_W(8)) mb ();
   spike_collector_if #(.NEURONS(2), .CNT_W(4)) sb ();
   spike_collector #(.NEURONS(2), .CNT_W(8), .WINDOW(100), .ACK_DELAY(AD)) u_dut (.clk(clk), .rst(rst), .sc_io(mb));
   spike_collector #(.NEURONS(2), .CNT_W(4), .WINDOW(300), .ACK_DELAY(AD)) u_sat (.clk(clk), .rst(rst), .sc_io(sb));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic go(input bit s);
      if (s) sb.start = 1'b1; else mb.start = 1'b1;
      tick();
      sb.start = 1'b0;
      mb.start = 1'b0;
      s0 = cyc;
   endtask
   // cycle k of the current window (cycle 1 = first busy cycle)
   task automatic at(input int k);
      while (cyc < s0 + k - 1) tick();
   endtask
   task automatic hs(input bit s, input logic [1:0] m);
      logic [1:0] a;
      if (s) sb.req = m; else mb.req = m;
      a = '0;
      for (int i = 0; i < 20; i++) begin
         a = s ? sb.ack : mb.ack;
         if ((a & m) == m) break;
         tick();
      end
      check("hs_rise", a & m, m);
      if (s) sb.req = '0; else mb.req = '0;
      for (int i = 0; i < 20; i++) begin
         a = s ? sb.ack : mb.ack;
         if ((a & m) == 2'b00) break;
         tick();
      end
      check("hs_fall", a & m, 0);
   endtask
   initial begin
      mb.req = '0; mb.start = 1'b0; sb.req = '0; sb.start = 1'b0;
      tick(3);
      rst = 1'b0;
      check("rst_ack", mb.ack, 0);
      check("rst_busy", mb.busy, 0);
      check("rst_rv", mb.result_valid, 0);
      check("rst_winner", mb.winner, 0);
      check("rst_counts", mb.counts, 0);
      check("rst_sat_counts", sb.counts, 0);
      mb.req = 2'b01;
      tick(RISE - 1);
      check("lat_rise_early", mb.ack, 2'b00);
      tick();
      check("lat_rise", mb.ack, 2'b01);
      mb.req = 2'b00;
      tick(FALL - 1);
      check("lat_fall_early", mb.ack, 2'b01);
      tick();
      check("lat_fall", mb.ack, 2'b00);
      check("lat_nocount", mb.counts, 0);
      go(0);
      check("win_busy", mb.busy, 1);
      repeat (3) hs(0, 2'b11);
      repeat (4) hs(0, 2'b01);
      at(100);
      check("win_last_busy", mb.busy, 1);
      check("win_last_rv", mb.result_valid, 0);
      tick();
      check("win_rv", mb.result_valid, 1);
      check("win_busy_off", mb.busy, 0);
      check("win_counts", mb.counts, 16'h0307);
      check("win_winner", mb.winner, 0);
      tick();
      check("win_rv_pulse", mb.result_valid, 0);
      check("win_hold", mb.counts, 16'h0307);
      go(0);
      hs(0, 2'b11); hs(0, 2'b10); hs(0, 2'b10);
      at(101);
      check("w1_rv", mb.result_valid, 1);
      check("w1_counts", mb.counts, 16'h0301);
      check("w1_winner", mb.winner, 1);
      go(0);
      repeat (4) hs(0, 2'b11);
      at(101);
      check("tie_rv", mb.result_valid, 1);
      check("tie_counts", mb.counts, 16'h0404);
      check("tie_winner", mb.winner, 0);
      hs(0, 2'b10); hs(0, 2'b10);
      check("idle_counts", mb.counts, 16'h0404);
      check("idle_winner", mb.winner, 0);
      go(0);
      hs(0, 2'b01);
      at(50);
      check("rs_pre", mb.counts, 16'h0001);
      old = s0;
      go(0);
      check("rs_clr", mb.counts, 0);
      check("rs_busy", mb.busy, 1);
      at(51);
      check("rs_old_end", mb.result_valid, 0);
      at(100);
      check("rs_last", mb.result_valid, 0);
      tick();
      check("rs_rv", mb.result_valid, 1);
      check("rs_cyc", cyc - old, 150);
      go(0);
      check("rv_start_busy", mb.busy, 1);
      hs(0, 2'b01);
      check("col_pre", mb.counts, 16'h0001);
      mb.req = 2'b01;
      tick(RISE - 1);
      mb.start = 1'b1;
      tick();
      mb.start = 1'b0;
      check("col_ack", mb.ack, 2'b01);
      check("col_clr", mb.counts, 0);
      mb.req = 2'b00;
      tick(FALL);
      check("col_fall", mb.ack, 2'b00);
      mb.req = 2'b10;
      tick(RISE);
      check("rr_ack", mb.ack, 2'b10);
      check("rr_cnt", mb.counts, 16'h0100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_drop", mb.ack, 2'b00);
      check("rr_counts", mb.counts, 0);
      check("rr_busy", mb.busy, 0);
      tick(RISE - 1);
      check("rr_wait", mb.ack, 2'b00);
      tick();
      check("rr_reack", mb.ack, 2'b10);
      check("rr_nocount", mb.counts, 0);
      mb.req = 2'b00;
      tick(FALL);
      check("rr_fall", mb.ack, 2'b00);
      go(1);
      repeat (20) hs(1, 2'b10);
      at(301);
      check("sat_rv", sb.result_valid, 1);
      check("sat_counts", sb.counts, 8'hF0);
      check("sat_winner", sb.winner, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
